// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and defaults for the sequential divider
//
// Purpose: state encoding, default operand widths and the iteration-counter
// width helper used by divider_seq and its datapath step.
package divider_pkg;

  localparam int DEF_WIDTH_N = 8;  // dividend / quotient width
  localparam int DEF_WIDTH_D = 4;  // divisor / remainder width

  // Counter must be able to hold the value WIDTH_N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH_N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step (combinational)
//
// Purpose: shift the partial remainder left taking in one dividend bit,
// subtract the divisor when it fits and report the resulting quotient bit.
// Ports:
//   i_prem    [WIDTH_D:0]   current partial remainder
//   i_bit                   next dividend bit (MSB first)
//   i_divisor [WIDTH_D-1:0] divisor
//   o_prem    [WIDTH_D:0]   next partial remainder
//   o_qbit                  quotient bit produced by this step
module div_step #(
  parameter int WIDTH_D = 4
) (
  input  logic [WIDTH_D:0]   i_prem,
  input  logic               i_bit,
  input  logic [WIDTH_D-1:0] i_divisor,
  output logic [WIDTH_D:0]   o_prem,
  output logic               o_qbit
);

  // One extra bit of headroom so the shift never loses information; the
  // restored result always fits back into WIDTH_D+1 bits.
  logic [WIDTH_D+1:0] w_shift;
  logic [WIDTH_D+1:0] w_dvs_ext;

  always_comb begin
    w_shift   = {i_prem, i_bit};
    w_dvs_ext = {2'b00, i_divisor};
    o_qbit    = (w_shift >= w_dvs_ext);
    o_prem    = o_qbit ? (WIDTH_D+1)'(w_shift - w_dvs_ext)
                       : (WIDTH_D+1)'(w_shift);
  end

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
//
// Purpose: divides an unsigned WIDTH_N-bit dividend by a WIDTH_D-bit divisor
// using a start/busy/done handshake. Latency is WIDTH_N cycles, or one cycle
// for a zero divisor.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start                     request; sampled only in IDLE
//   dividend  [WIDTH_N-1:0]   captured on the accepted start edge
//   divisor   [WIDTH_D-1:0]   captured on the accepted start edge
//   quotient  [WIDTH_N-1:0]   result, valid from done until the next start
//   remainder [WIDTH_D-1:0]   result, same validity as quotient
//   busy                      division in progress
//   done                      one-cycle result-valid pulse
//   div_zero                  captured divisor was zero (held with results)
//   sinal                     sign flag, always 0 (unsigned)
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               sinal
);

  localparam int CW = cnt_width(WIDTH_N);

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH_D:0]   r_prem;
  // Holds the dividend on entry; dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so it ends up holding the quotient.
  logic [WIDTH_N-1:0] r_dvd;
  logic [WIDTH_D-1:0] r_dvs;
  logic [WIDTH_N-1:0] r_quotient;
  logic [WIDTH_D-1:0] r_remainder;
  logic               r_done;
  logic               r_div_zero;

  logic [WIDTH_D:0]   w_step_prem;
  logic               w_qbit;
  logic               w_accept;
  logic               w_zero_div;
  logic               w_last;
  logic               w_busy;

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_dvd[WIDTH_N-1]),
    .i_divisor (r_dvs),
    .o_prem    (w_step_prem),
    .o_qbit    (w_qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = RUN;
      RUN:  if (w_zero_div || w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept   = (r_state == IDLE) && start;
    w_zero_div = (r_dvs == '0);
    w_last     = (r_cnt == CW'(1));
    w_busy     = (r_state == RUN);
  end

  // Datapath and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_prem      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dvd      <= dividend;
        r_dvs      <= divisor;
        r_prem     <= '0;
        r_cnt      <= CW'(WIDTH_N);
        r_div_zero <= 1'b0;
      end else if (r_state == RUN) begin
        if (w_zero_div) begin
          // r_dvd has not shifted yet, so its low bits are the raw dividend.
          r_quotient  <= '1;
          r_remainder <= r_dvd[WIDTH_D-1:0];
          r_div_zero  <= 1'b1;
          r_done      <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_prem <= w_step_prem;
          r_dvd  <= {r_dvd[WIDTH_N-2:0], w_qbit};
          r_cnt  <= r_cnt - CW'(1);
          if (w_last) begin
            // Partial remainder is below the divisor here, so its top bit is 0.
            r_quotient  <= {r_dvd[WIDTH_N-2:0], w_qbit};
            r_remainder <= w_step_prem[WIDTH_D-1:0];
            r_done      <= 1'b1;
          end
        end
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = w_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign sinal     = 1'b0;

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - self-checking bench for divider_seq
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic       sinal;

  int n_assert = 0;
  int n_fail   = 0;

  divider_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .sinal     (sinal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a request; returns #1 after the accepting edge with operands scrambled.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Bounded wait for done; counts cycles and cycles with busy high.
  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) nb++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] a, input logic [3:0] b,
                              input int lat, input int nb);
    int         exp_q;
    int         exp_r;
    int         exp_lat;
    bit         z;
    logic [7:0] prod;
    z = (b == 4'd0);
    if (z) begin
      exp_q   = 255;
      exp_r   = a % 16;
      exp_lat = 1;
    end else begin
      exp_q   = a / b;
      exp_r   = a % b;
      exp_lat = 8;
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_cycles"}, nb, exp_lat);
    chk({tag, ".quotient"}, quotient, exp_q);
    chk({tag, ".remainder"}, remainder, exp_r);
    chk({tag, ".div_zero"}, div_zero, z);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".sinal"}, sinal, 0);
    if (!z) begin
      chk({tag, ".invariant"}, int'(quotient) * int'(b) + int'(remainder), a);
      chk({tag, ".rem_lt_div"}, (remainder < b), 1);
      if (quotient < 8'd16) begin
        prod = {4'b0, quotient[3:0]} * {4'b0, b};
        chk({tag, ".mult_roundtrip"}, prod + {4'b0, remainder}, a);
      end
    end
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk);
    #1;
    chk({tag, ".done_one_cycle"}, done, 0);
  endtask

  task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b);
    int lat;
    int nb;
    launch(a, b);
    chk({tag, ".busy_after_start"}, busy, 1);
    chk({tag, ".done_after_start"}, done, 0);
    chk({tag, ".dz_after_start"}, div_zero, 0);
    wait_done(lat, nb);
    check_result(tag, a, b, lat, nb);
    check_pulse_end(tag);
  endtask

  initial begin
    int lat;
    int nb;
    int n_done;
    logic [7:0] ra;
    logic [3:0] rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.quotient", quotient, 0);
    chk("reset.remainder", remainder, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.div_zero", div_zero, 0);
    chk("reset.sinal", sinal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div("d200_7", 8'd200, 4'd7);
    do_div("d255_1", 8'd255, 4'd1);
    do_div("d15_15", 8'd15, 4'd15);
    do_div("d0_5", 8'd0, 4'd5);
    do_div("d100_13", 8'd100, 4'd13);
    do_div("d9_0", 8'd9, 4'd0);

    // Start pulsed while busy with new operands must be ignored.
    launch(8'd200, 4'd7);
    lat    = 0;
    nb     = 1;
    n_done = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == 2) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (busy === 1'b1) nb++;
    end
    check_result("busy_start", 8'd200, 4'd7, lat, nb);
    // Back-to-back: request raised during the done cycle.
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b.busy_after_start", busy, 1);
    chk("b2b.no_extra_done", done, 0);
    wait_done(lat, nb);
    check_result("b2b_50_3", 8'd50, 4'd3, lat, nb);
    check_pulse_end("b2b_50_3");

    // Reset in the middle of a run aborts it.
    launch(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.quotient", quotient, 0);
    chk("midrst.remainder", remainder, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.div_zero", div_zero, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    chk("midrst.no_done_or_busy", n_done, 0);
    do_div("after_rst_120_11", 8'd120, 4'd11);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 4'($urandom);
      do_div("rand", ra, rb);
    end

    // Exhaustive sweep, chained back-to-back through the done cycle.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_done(lat, nb);
        check_result("sweep", 8'(a), 4'(b), lat, nb);
      end
    end
    check_pulse_end("sweep_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Takes an 8-bit dividend and a 4-bit divisor and produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Uses a start/busy/done handshake and sits beside the multiplier in the arithmetic datapath.
- For any quotient below 16, the result round-trips through the multiplier.

Parameters:
- WIDTH_N, 8: dividend and quotient width.
- WIDTH_D, 4: divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a division; sampled only in IDLE.
- dividend  input  WIDTH_N  unsigned dividend; captured on the accepted start edge.
- divisor  input  WIDTH_D  unsigned divisor; captured on the accepted start edge.
- quotient  output  WIDTH_N  result quotient; valid from the done edge until the next accepted start.
- remainder  output  WIDTH_D  result remainder; same validity as quotient.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse marking results valid.
- div_zero  output  1  high with done when the captured divisor was 0; held with the results.
- sinal  output  1  sign flag; constant 0 (unsigned operation), matching the multiplier's interface.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; quotient 0, remainder 0, busy 0, done 0, div_zero 0; internal counter and partial remainder cleared.
- A reset in the middle of an operation aborts it; no done pulse follows.
- States: IDLE and RUN.
- Accepting a request (edge E0): start high in IDLE latches the operands.
  - busy goes high.
  - done and div_zero are cleared.
  - Iteration counter is loaded with WIDTH_N.
  - State becomes RUN.
- Each RUN edge performs one restoring step:
  - The partial remainder (WIDTH_D+1 bits) is shifted left, taking in the next dividend MSB.
  - If the partial remainder is >= divisor, subtract the divisor and shift a 1 into the quotient; otherwise shift a 0.
  - The counter decrements.
- Completion: on edge E_WIDTH_N (E8 by default) the final quotient and remainder are registered.
  - done rises and busy falls on that same edge; state returns to IDLE.
  - Start-to-done latency is WIDTH_N cycles.
- done is high for exactly one cycle.
- Outputs hold their values until the next accepted start.
- Back-to-back operation: a start asserted during the done cycle is accepted (state is already IDLE).
- Zero divisor: RUN lasts a single cycle. On E1:
  - quotient = all ones and remainder = dividend[WIDTH_D-1:0];
  - div_zero = 1, done = 1, busy = 0.
- Start while busy: ignored, and the in-flight operands are unaffected.
- Operand inputs changing after E0 have no effect on the result.
- Invariant when div_zero = 0: quotient*divisor + remainder == dividend, and remainder < divisor.
- No overflow is possible: the quotient is WIDTH_N wide and always fits.

Decomposition:
- Shared package divider_pkg holds:
  - the state enum (IDLE, RUN);
  - WIDTH_N and WIDTH_D defaults;
  - the counter width, $clog2(WIDTH_N+1).
- One combinational sub-module is natural: div_step.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once and reused each cycle.

Test Plan:
- 200/7: start, dividend=8'd200, divisor=4'd7 -> done 8 cycles later; quotient=28, remainder=4, div_zero=0; busy high for exactly 8 cycles.
- 255/1, 15/15, 0/5 -> (255,0), (1,0), (0,0); 100/13 -> (7,9).
- 9/0 -> done after 1 cycle; quotient=8'hFF, remainder=9, div_zero=1.
- start pulsed at cycle 3 of a 200/7 run, with operands changed to 50/3 -> ignored; result still (28,4) with no extra done pulse.
  - Then a start during the done cycle with 50/3 -> (16,2) after 8 more cycles.
- rst_n low at cycle 4 of a run -> all outputs 0 immediately; no done pulse.
  - A following 120/11 run completes normally with (10,10).
- Exhaustive sweep of all 256x16 operand pairs:
  - divisor 0 -> div_zero=1, quotient=8'hFF, remainder=dividend[3:0].
  - otherwise -> invariant holds, and for quotient<16 the multiplier's product of quotient and divisor plus remainder equals dividend.
  - sinal always 0.
